// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and LSU access to one single-ported memory with a fixed access latency.
// Optional `define MEM_ARB_RR_EN selects round-robin on contention (default: data > inst).
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {
        MEM_DISABLE  = 2'd0,
        MEM_READ_EN  = 2'd1,
        MEM_WRITE_EN = 2'd2
    } mem_en_t;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_flush,
    output logic        inst_ready,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_be,
    output logic        data_ready,
    output logic [31:0] data_rdata,
    output mem_en_t     mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned    CntW    = $clog2(MEM_LATENCY + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LATENCY - 1);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 8) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be 1..8");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;
    typedef enum logic {OwnInst, OwnData} owner_t;

    state_t          state_q;
    owner_t          owner_q;
    owner_t          last_grant_q;
    logic [CntW-1:0] lat_cnt_q;
    logic [31:0]     rdata_q;
    logic            inst_rdy_q;
    logic            kill_q;
    logic            grant_data;

    always_comb begin
`ifdef MEM_ARB_RR_EN
        if (inst_req && data_req) grant_data = (last_grant_q == OwnInst);
        else                      grant_data = data_req;
`else
        grant_data = data_req;
`endif
    end

`ifndef MEM_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            owner_q      <= OwnInst;
            last_grant_q <= OwnInst;
            lat_cnt_q    <= '0;
            mem_op       <= MEM_DISABLE;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            rdata_q      <= '0;
            inst_rdy_q   <= 1'b0;
            data_ready   <= 1'b0;
            kill_q       <= 1'b0;
        end else begin
            inst_rdy_q <= 1'b0;
            data_ready <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    kill_q <= 1'b0;
                    if (inst_req || data_req) begin
                        state_q   <= StBusy;
                        lat_cnt_q <= CntLoad;
                        if (grant_data) begin
                            owner_q      <= OwnData;
                            last_grant_q <= OwnData;
                            mem_addr     <= data_addr;
                            mem_wdata    <= data_wdata;
                            mem_op       <= data_we ? MEM_WRITE_EN : MEM_READ_EN;
                            mem_be       <= data_we ? data_be : 4'hF;
                        end else begin
                            owner_q      <= OwnInst;
                            last_grant_q <= OwnInst;
                            mem_addr     <= inst_addr;
                            mem_wdata    <= '0;
                            mem_op       <= MEM_READ_EN;
                            mem_be       <= 4'hF;
                        end
                    end
                end
                StBusy: begin
                    if (owner_q == OwnInst && inst_flush) kill_q <= 1'b1;
                    if (lat_cnt_q != '0) begin
                        lat_cnt_q <= lat_cnt_q - CntW'(1);
                    end else begin
                        state_q <= StResp;
                        mem_op  <= MEM_DISABLE;
                        rdata_q <= (mem_op == MEM_READ_EN) ? mem_rdata : '0;
                        // A flush in the final busy cycle must also cancel the response.
                        if (owner_q == OwnInst) inst_rdy_q <= !kill_q && !inst_flush;
                        else                    data_ready <= 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    kill_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // inst_rdy_q is only set for an instruction owner, so a flush in RESP just masks it.
    assign inst_ready = inst_rdy_q && !inst_flush;
    assign inst_rdata = rdata_q;
    assign data_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LATENCY=2: vector table plus reset-abort
// and contention sequences against a latency-aware memory model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        inst_req, inst_flush, inst_ready;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_we, data_ready;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be, mem_be;
    mem_en_t     mem_op;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_bad = 0;
    int bcnt  = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.MEM_LATENCY(LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
        .inst_ready(inst_ready), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_be(data_be),
        .data_ready(data_ready), .data_rdata(data_rdata),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0040: return 32'h00A0_0113;
            32'h0000_3000: return 32'hCAFE_F00D;
            32'h0000_3004: return 32'h1234_5678;
            default:       return 32'hBAD0_BAD0;
        endcase
    endfunction

    // Memory data is only valid in the last busy cycle; garbage otherwise.
    always @(posedge clock) bcnt <= (mem_op == MEM_DISABLE) ? 0 : bcnt + 1;
    assign mem_rdata = (mem_op == MEM_READ_EN && bcnt == LAT - 1) ? mem_word(mem_addr)
                                                                   : 32'hFFFF_FFFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          flush_cyc;
        mem_en_t     exp_op;
        logic [3:0]  exp_be;
        logic        exp_ready;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic d, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be, input int fc,
                                input mem_en_t op, input logic [3:0] ebe, input logic rdy,
                                input logic [31:0] rd);
        vec_t v;
        v.is_data = d; v.we = we; v.addr = a; v.wdata = wd; v.be = be; v.flush_cyc = fc;
        v.exp_op = op; v.exp_be = ebe; v.exp_ready = rdy; v.exp_rdata = rd;
        return v;
    endfunction

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input int idx);
        inst_req   = !v.is_data;
        data_req   = v.is_data;
        inst_addr  = v.addr;
        data_addr  = v.addr;
        data_we    = v.we;
        data_wdata = v.wdata;
        data_be    = v.be;
        for (int c = 0; c <= LAT + 1; c++) begin
            if (c > 0) begin @(posedge clock); #1; end
            inst_flush = (c == v.flush_cyc);
            @(negedge clock);
            if (c == 0) begin
                chk($sformatf("v%0d idle op", idx), 32'(mem_op), 32'(MEM_DISABLE));
            end else if (c <= LAT) begin
                chk($sformatf("v%0d c%0d op", idx, c), 32'(mem_op), 32'(v.exp_op));
                chk($sformatf("v%0d c%0d addr", idx, c), mem_addr, v.addr);
                chk($sformatf("v%0d c%0d be", idx, c), 32'(mem_be), 32'(v.exp_be));
                if (v.we) chk($sformatf("v%0d c%0d wdata", idx, c), mem_wdata, v.wdata);
                chk($sformatf("v%0d c%0d rdy", idx, c), {30'd0, inst_ready, data_ready}, 0);
            end else begin
                chk($sformatf("v%0d resp op", idx), 32'(mem_op), 32'(MEM_DISABLE));
                chk($sformatf("v%0d inst_ready", idx), 32'(inst_ready),
                    32'(v.exp_ready && !v.is_data));
                chk($sformatf("v%0d data_ready", idx), 32'(data_ready),
                    32'(v.exp_ready && v.is_data));
                if (v.exp_ready) begin
                    chk($sformatf("v%0d inst_rdata", idx), inst_rdata, v.exp_rdata);
                    chk($sformatf("v%0d data_rdata", idx), data_rdata, v.exp_rdata);
                end
            end
        end
        @(posedge clock); #1;
        inst_req = 1'b0; data_req = 1'b0; inst_flush = 1'b0;
    endtask

    initial begin
        vecs[0] = mk(0, 0, 32'h100,  32'h0,         4'h0, -1, MEM_READ_EN,  4'hF, 1, 32'h00500093);
        vecs[1] = mk(1, 1, 32'h2000, 32'hDEADBEEF,  4'h3, -1, MEM_WRITE_EN, 4'h3, 1, 32'h0);
        vecs[2] = mk(1, 0, 32'h3000, 32'h55555555,  4'h1, -1, MEM_READ_EN,  4'hF, 1, 32'hCAFEF00D);
        vecs[3] = mk(1, 1, 32'h3004, 32'h0BADF00D,  4'hC, -1, MEM_WRITE_EN, 4'hC, 1, 32'h0);
        vecs[4] = mk(0, 0, 32'h40,   32'h0,         4'h0,  1, MEM_READ_EN,  4'hF, 0, 32'h0);
        vecs[5] = mk(0, 0, 32'h40,   32'h0,         4'h0, -1, MEM_READ_EN,  4'hF, 1, 32'h00A00113);
        vecs[6] = mk(0, 0, 32'h100,  32'h0,         4'h0,  2, MEM_READ_EN,  4'hF, 0, 32'h0);
        vecs[7] = mk(0, 0, 32'h100,  32'h0,         4'h0,  3, MEM_READ_EN,  4'hF, 0, 32'h0);
        vecs[8] = mk(0, 0, 32'h3004, 32'h0,         4'h0,  0, MEM_READ_EN,  4'hF, 1, 32'h12345678);
        vecs[9] = mk(1, 0, 32'h3000, 32'h0,         4'hF,  1, MEM_READ_EN,  4'hF, 1, 32'hCAFEF00D);

        reset_n = 1'b0;
        inst_req = 1'b0; inst_addr = '0; inst_flush = 1'b0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_be = '0;
        #3;
        chk("reset op", 32'(mem_op), 32'(MEM_DISABLE));
        chk("reset addr", mem_addr, 32'h0);
        chk("reset wdata", mem_wdata, 32'h0);
        chk("reset be", 32'(mem_be), 32'h0);
        chk("reset ready", {30'd0, inst_ready, data_ready}, 32'h0);
        chk("reset rdata", inst_rdata | data_rdata, 32'h0);
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset asserted mid-access aborts it without a ready.
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h3000;
        @(posedge clock); #1;
        @(negedge clock);
        chk("abort busy op", 32'(mem_op), 32'(MEM_READ_EN));
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort op now", 32'(mem_op), 32'(MEM_DISABLE));
        chk("abort addr", mem_addr, 32'h0);
        data_req = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk($sformatf("abort c%0d ready", c), 32'(data_ready), 32'h0);
            chk($sformatf("abort c%0d op", c), 32'(mem_op), 32'(MEM_DISABLE));
        end
        @(posedge clock); #1;

        // Contention: data wins, inst is served in the following round.
        inst_req = 1'b1; inst_addr = 32'h100;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h3004;
        for (int c = 0; c <= 2 * LAT + 3; c++) begin
            if (c > 0) begin @(posedge clock); #1; end
            if (c == LAT + 2) data_req = 1'b0;
            @(negedge clock);
            chk($sformatf("cont c%0d data_ready", c), 32'(data_ready), 32'(c == LAT + 1));
            chk($sformatf("cont c%0d inst_ready", c), 32'(inst_ready), 32'(c == 2 * LAT + 3));
            if (c == 1)            chk("cont data addr", mem_addr, 32'h3004);
            if (c == LAT + 3)      chk("cont inst addr", mem_addr, 32'h100);
            if (c == LAT + 1)      chk("cont data rdata", data_rdata, 32'h12345678);
            if (c == 2 * LAT + 3)  chk("cont inst rdata", inst_rdata, 32'h00500093);
        end
        @(posedge clock); #1;
        inst_req = 1'b0;
        @(negedge clock);
        chk("final idle op", 32'(mem_op), 32'(MEM_DISABLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
